// File: rtl/mem_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter_rr
// Purpose  : CNT-to-1 memory request arbiter with fixed or round-robin
//            selection, per-master caps and in-order response routing.
// Revision : 1.0
// ============================================================================
module mem_arbiter_rr #(
  parameter int CNT             = 2,
  parameter int REQ_WIDTH       = 64,
  parameter int RESP_WIDTH      = 32,
  parameter int QUEUE_DEPTH     = 4,
  parameter int MAX_OUTSTANDING = 2,
  parameter int MODE            = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [CNT-1:0]                   master_req_valid,
  output logic [CNT-1:0]                   master_req_ready,
  input  logic [CNT*REQ_WIDTH-1:0]         master_req_data,
  output logic [CNT-1:0]                   master_resp_valid,
  input  logic [CNT-1:0]                   master_resp_ready,
  output logic [RESP_WIDTH-1:0]            master_resp_data,
  output logic                             slave_req_valid,
  input  logic                             slave_req_ready,
  output logic [REQ_WIDTH-1:0]             slave_req_data,
  input  logic                             slave_resp_valid,
  output logic                             slave_resp_ready,
  input  logic [RESP_WIDTH-1:0]            slave_resp_data,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0] inflight
);

  localparam int IDX_W    = (CNT > 1) ? $clog2(CNT) : 1;
  localparam int c_sum_w  = IDX_W + 1;
  localparam int c_cnt_w  = $clog2(MAX_OUTSTANDING + 1);
  localparam int c_occ_w  = $clog2(QUEUE_DEPTH + 1);
  localparam int c_ptr_w  = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam logic [c_cnt_w-1:0] c_max_out = c_cnt_w'(MAX_OUTSTANDING);
  localparam logic [c_occ_w-1:0] c_depth   = c_occ_w'(QUEUE_DEPTH);
  localparam logic [c_ptr_w-1:0] c_ptr_end = c_ptr_w'(QUEUE_DEPTH - 1);
  localparam logic [IDX_W-1:0]   c_idx_end = IDX_W'(CNT - 1);

  logic [IDX_W-1:0]   r_fifo [QUEUE_DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr, r_rd_ptr;
  logic [c_occ_w-1:0] r_count;
  logic [c_cnt_w-1:0] r_outst [CNT];
  logic [IDX_W-1:0]   r_rr_ptr, r_lock_idx;
  logic               r_lock;

  logic [REQ_WIDTH-1:0] w_req_arr [CNT];
  logic [CNT-1:0]       w_elig, w_inc, w_dec;
  logic [IDX_W-1:0]     w_sel_fp, w_sel_rr, w_sel, w_grant, w_head;
  logic                 w_any, w_full, w_nonempty, w_fire, w_pop;

  for (genvar i = 0; i < CNT; i++) begin : g_port
    assign w_req_arr[i]         = master_req_data[i*REQ_WIDTH +: REQ_WIDTH];
    assign w_elig[i]            = master_req_valid[i] && (r_outst[i] < c_max_out);
    assign w_inc[i]             = w_fire && (w_grant == IDX_W'(i));
    assign w_dec[i]             = w_pop && (w_head == IDX_W'(i));
    assign master_req_ready[i]  = w_inc[i];
    assign master_resp_valid[i] = slave_resp_valid && w_nonempty && (w_head == IDX_W'(i));

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
      !(w_inc[i] && !w_dec[i] && (r_outst[i] == c_max_out)));
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst)
      !(w_dec[i] && !w_inc[i] && (r_outst[i] == '0)));
  end

  always_comb begin
    w_sel_fp = '0;
    for (int i = CNT - 1; i >= 0; i--) begin
      if (w_elig[i]) w_sel_fp = IDX_W'(i);
    end
  end

  // Rotating scan; the extra sum bit keeps the wrap correct for non-power-of-two CNT.
  always_comb begin
    logic [c_sum_w-1:0] v_sum;
    logic [IDX_W-1:0]   v_idx;
    logic               v_found;
    w_sel_rr = '0;
    v_found  = 1'b0;
    for (int k = 0; k < CNT; k++) begin
      v_sum = {1'b0, r_rr_ptr} + c_sum_w'(k);
      v_idx = IDX_W'((v_sum >= c_sum_w'(CNT)) ? (v_sum - c_sum_w'(CNT)) : v_sum);
      if (!v_found && w_elig[v_idx]) begin
        w_sel_rr = v_idx;
        v_found  = 1'b1;
      end
    end
  end

  assign w_any      = |w_elig;
  assign w_sel      = (MODE == 1) ? w_sel_rr : w_sel_fp;
  assign w_grant    = r_lock ? r_lock_idx : w_sel;
  assign w_full     = (r_count == c_depth);
  assign w_nonempty = (r_count != '0);
  assign w_head     = r_fifo[r_rd_ptr];

  // Gated by rst so every handshake output is low the moment reset asserts.
  assign slave_req_valid  = rst && (r_lock || w_any) && !w_full;
  assign slave_req_data   = w_req_arr[w_grant];
  assign w_fire           = slave_req_valid && slave_req_ready;
  assign slave_resp_ready = w_nonempty && master_resp_ready[w_head];
  assign w_pop            = slave_resp_valid && slave_resp_ready;
  assign master_resp_data = slave_resp_data;
  assign inflight         = r_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) r_fifo[i] <= '0;
      for (int i = 0; i < CNT; i++) r_outst[i] <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_rr_ptr   <= '0;
      r_lock     <= 1'b0;
      r_lock_idx <= '0;
    end else begin
      if (w_fire) begin
        r_fifo[r_wr_ptr] <= w_grant;
        r_wr_ptr         <= (r_wr_ptr == c_ptr_end) ? '0 : r_wr_ptr + 1'b1;
        r_rr_ptr         <= (w_grant == c_idx_end) ? '0 : w_grant + 1'b1;
      end
      if (w_pop) r_rd_ptr <= (r_rd_ptr == c_ptr_end) ? '0 : r_rd_ptr + 1'b1;

      case ({w_fire, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      for (int i = 0; i < CNT; i++) begin
        if (w_inc[i] && !w_dec[i])      r_outst[i] <= r_outst[i] + 1'b1;
        else if (w_dec[i] && !w_inc[i]) r_outst[i] <= r_outst[i] - 1'b1;
      end

      // Freeze the grant while the slave stalls so the payload cannot change mid-handshake.
      if (slave_req_valid && !slave_req_ready) begin
        r_lock     <= 1'b1;
        r_lock_idx <= w_grant;
      end else if (w_fire) begin
        r_lock <= 1'b0;
      end
    end
  end

  a_no_stray_resp: assert property (@(posedge clk) disable iff (!rst)
    !(slave_resp_valid && !w_nonempty));

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter_rr.sv
`default_nettype none
// Two arbiters (round-robin cap 2, fixed-priority cap 4) compared each cycle
// against a queue model, plus directed literal expectations.
module tb_mem_arbiter_rr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstv  [2];
  logic [3:0]  mv    [2];
  logic [3:0]  mrr   [2];
  logic [63:0] mdat  [2];
  logic        sreqr [2];
  logic        srspv [2];
  logic [7:0]  srspd [2];

  logic [3:0]  d_mreq_ready  [2];
  logic [3:0]  d_mresp_valid [2];
  logic [7:0]  d_mresp_data  [2];
  logic        d_sreq_valid  [2];
  logic [15:0] d_sreq_data   [2];
  logic        d_sresp_ready [2];
  logic [2:0]  d_inflight    [2];

  mem_arbiter_rr #(.CNT(4), .REQ_WIDTH(16), .RESP_WIDTH(8), .QUEUE_DEPTH(4),
                   .MAX_OUTSTANDING(2), .MODE(1)) u_rr (
    .clk(clk), .rst(rstv[0]),
    .master_req_valid(mv[0]), .master_req_ready(d_mreq_ready[0]),
    .master_req_data(mdat[0]), .master_resp_valid(d_mresp_valid[0]),
    .master_resp_ready(mrr[0]), .master_resp_data(d_mresp_data[0]),
    .slave_req_valid(d_sreq_valid[0]), .slave_req_ready(sreqr[0]),
    .slave_req_data(d_sreq_data[0]), .slave_resp_valid(srspv[0]),
    .slave_resp_ready(d_sresp_ready[0]), .slave_resp_data(srspd[0]),
    .inflight(d_inflight[0]));

  mem_arbiter_rr #(.CNT(4), .REQ_WIDTH(16), .RESP_WIDTH(8), .QUEUE_DEPTH(4),
                   .MAX_OUTSTANDING(4), .MODE(0)) u_fp (
    .clk(clk), .rst(rstv[1]),
    .master_req_valid(mv[1]), .master_req_ready(d_mreq_ready[1]),
    .master_req_data(mdat[1]), .master_resp_valid(d_mresp_valid[1]),
    .master_resp_ready(mrr[1]), .master_resp_data(d_mresp_data[1]),
    .slave_req_valid(d_sreq_valid[1]), .slave_req_ready(sreqr[1]),
    .slave_req_data(d_sreq_data[1]), .slave_resp_valid(srspv[1]),
    .slave_resp_ready(d_sresp_ready[1]), .slave_resp_data(srspd[1]),
    .inflight(d_inflight[1]));

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Model state: in-order queue of granted master indices, per-master counts.
  int q    [2][4];
  int qn   [2];
  int outs [2][4];
  int rr   [2];
  bit lk   [2];
  int lidx [2];
  int mo_of [2] = '{2, 4};
  int md_of [2] = '{1, 0};

  task automatic model_cycle(input int k);
    int g, head;
    bit ev, fire, pop;
    logic [3:0] one, er, erv;
    logic [15:0] ed;
    bit esr;
    string s;
    one = 4'b0001;
    s = (k == 0) ? "rr" : "fp";
    if (!rstv[k]) begin
      chk({s, ".rst_sreq_valid"},  d_sreq_valid[k],  1'b0);
      chk({s, ".rst_req_ready"},   d_mreq_ready[k],  4'b0);
      chk({s, ".rst_resp_valid"},  d_mresp_valid[k], 4'b0);
      chk({s, ".rst_sresp_ready"}, d_sresp_ready[k], 1'b0);
      chk({s, ".rst_inflight"},    d_inflight[k],    3'd0);
      qn[k] = 0; rr[k] = 0; lk[k] = 0; lidx[k] = 0;
      for (int i = 0; i < 4; i++) outs[k][i] = 0;
      return;
    end
    g = -1;
    if (lk[k]) g = lidx[k];
    else if (md_of[k] == 0) begin
      for (int i = 3; i >= 0; i--) if (mv[k][i] && outs[k][i] < mo_of[k]) g = i;
    end else begin
      for (int n = 0; n < 4; n++) begin
        int i;
        i = (rr[k] + n) % 4;
        if (g < 0 && mv[k][i] && outs[k][i] < mo_of[k]) g = i;
      end
    end
    ev   = (g >= 0) && (qn[k] < 4);
    er   = (ev && sreqr[k]) ? (one << g) : 4'b0;
    head = (qn[k] > 0) ? q[k][0] : -1;
    erv  = (srspv[k] && head >= 0) ? (one << head) : 4'b0;
    esr  = (head >= 0) && mrr[k][head];
    chk({s, ".sreq_valid"},  d_sreq_valid[k],  ev);
    chk({s, ".req_ready"},   d_mreq_ready[k],  er);
    chk({s, ".resp_valid"},  d_mresp_valid[k], erv);
    chk({s, ".sresp_ready"}, d_sresp_ready[k], esr);
    chk({s, ".inflight"},    d_inflight[k],    qn[k]);
    if (ev) begin
      ed = mdat[k][g*16 +: 16];
      chk({s, ".sreq_data"}, d_sreq_data[k], ed);
    end
    if (erv != 4'b0) chk({s, ".resp_data"}, d_mresp_data[k], srspd[k]);
    fire = ev && sreqr[k];
    pop  = srspv[k] && (head >= 0) && mrr[k][head];
    if (ev && !sreqr[k]) begin lk[k] = 1; lidx[k] = g; end
    else if (fire) lk[k] = 0;
    if (pop) begin
      outs[k][head]--;
      for (int i = 0; i < 3; i++) q[k][i] = q[k][i+1];
      qn[k]--;
    end
    if (fire) begin
      q[k][qn[k]] = g;
      qn[k]++;
      outs[k][g]++;
      if (md_of[k] == 1) rr[k] = (g + 1) % 4;
    end
  endtask

  always @(negedge clk) begin
    model_cycle(0);
    model_cycle(1);
  end

  bit cnt_en = 0;
  int fires [4];
  int order [4];
  int nrec = 0;
  always @(negedge clk) begin
    if (cnt_en) begin
      for (int i = 0; i < 4; i++) begin
        if (d_mreq_ready[0][i]) begin
          fires[i]++;
          if (nrec < 4) begin order[nrec] = i; nrec++; end
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      rstv[k] = 1'b0; mv[k] = 4'hF; mrr[k] = 4'hF; sreqr[k] = 1'b1;
      srspv[k] = 1'b0; srspd[k] = 8'h00;
      mdat[k] = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    end
    for (int i = 0; i < 4; i++) begin fires[i] = 0; order[i] = -1; end
    step(2);
    chk("reset_inflight",   d_inflight[0],    3'd0);
    chk("reset_sreq_valid", d_sreq_valid[0],  1'b0);
    chk("reset_req_ready",  d_mreq_ready[0],  4'b0);
    chk("reset_resp_valid", d_mresp_valid[1], 4'b0);

    // Round-robin fairness: all four valid, responses one cycle behind.
    rstv[0] = 1'b1; rstv[1] = 1'b1; mv[1] = 4'b0; cnt_en = 1;
    step(1); srspv[0] = 1'b1; srspd[0] = 8'h77;
    step(39); cnt_en = 0; mv[0] = 4'b0;
    step(1); srspv[0] = 1'b0;
    for (int i = 0; i < 4; i++) chk($sformatf("rr_order%0d", i), order[i], i);
    for (int i = 0; i < 4; i++) chk($sformatf("rr_share%0d", i), fires[i], 10);
    settle(); chk("rr_drained", d_inflight[0], 3'd0);

    // Outstanding cap.
    step(1); mv[0] = 4'b0001;
    step(2); settle();
    chk("cap_m0_blocked", d_sreq_valid[0], 1'b0);
    chk("cap_inflight2",  d_inflight[0],   3'd2);
    step(1); mv[0] = 4'b0011; settle();
    chk("cap_m1_granted", d_mreq_ready[0], 4'b0010);
    step(1); mv[0] = 4'b0001; srspv[0] = 1'b1; srspd[0] = 8'h5A; settle();
    chk("cap_same_cycle", d_sreq_valid[0],  1'b0);
    chk("cap_resp_m0",    d_mresp_valid[0], 4'b0001);
    step(1); srspv[0] = 1'b0; settle();
    chk("cap_resume", d_mreq_ready[0], 4'b0001);
    step(1); mv[0] = 4'b0; srspv[0] = 1'b1;
    step(3); srspv[0] = 1'b0;

    // FIFO full: four in flight, a pop frees a slot only on the next cycle.
    mv[0] = 4'hF;
    step(4); srspv[0] = 1'b1; srspd[0] = 8'h33; settle();
    chk("full_inflight", d_inflight[0],   3'd4);
    chk("full_no_req",   d_sreq_valid[0], 1'b0);
    step(1); srspv[0] = 1'b0; settle();
    chk("full_freed_inflight", d_inflight[0],   3'd3);
    chk("full_freed_valid",    d_sreq_valid[0], 1'b1);
    chk("full_freed_grant",    d_mreq_ready[0], 4'b0010);
    step(1); mv[0] = 4'b0; srspv[0] = 1'b1;
    step(4); srspv[0] = 1'b0;

    // Ordered routing: requests from 2,0,1; responses A,B,C.
    mv[0] = 4'b0100; step(1);
    mv[0] = 4'b0001; step(1);
    mv[0] = 4'b0010; step(1);
    mv[0] = 4'b0000; srspv[0] = 1'b1; srspd[0] = 8'h0A; settle();
    chk("route_a_valid", d_mresp_valid[0], 4'b0100);
    chk("route_a_data",  d_mresp_data[0],  8'h0A);
    step(1); srspd[0] = 8'h0B; settle();
    chk("route_b_valid", d_mresp_valid[0], 4'b0001);
    chk("route_b_data",  d_mresp_data[0],  8'h0B);
    step(1); srspd[0] = 8'h0C; settle();
    chk("route_c_valid", d_mresp_valid[0], 4'b0010);
    chk("route_c_data",  d_mresp_data[0],  8'h0C);
    step(1); srspv[0] = 1'b0; settle();
    chk("route_drained", d_inflight[0], 3'd0);

    // Asynchronous reset with three in flight.
    step(1); mv[0] = 4'b0111;
    step(3); sreqr[0] = 1'b0; srspv[0] = 1'b1; srspd[0] = 8'h00; settle();
    chk("pre_rst_inflight",   d_inflight[0],    3'd3);
    chk("pre_rst_resp_valid", d_mresp_valid[0], 4'b0100);
    rstv[0] = 1'b0; #1;
    chk("rst_async_inflight",    d_inflight[0],    3'd0);
    chk("rst_async_resp_valid",  d_mresp_valid[0], 4'b0);
    chk("rst_async_sreq_valid",  d_sreq_valid[0],  1'b0);
    chk("rst_async_sresp_ready", d_sresp_ready[0], 1'b0);
    step(1); mv[0] = 4'b0; srspv[0] = 1'b0; sreqr[0] = 1'b1;
    step(1); rstv[0] = 1'b1; settle();
    chk("post_rst_inflight", d_inflight[0], 3'd0);

    // Fixed priority: masters 0 and 2 valid, only 0 wins.
    step(1); mv[1] = 4'b0101; settle();
    chk("fp_grant0", d_mreq_ready[1], 4'b0001);
    for (int n = 0; n < 5; n++) begin
      step(1); srspv[1] = 1'b1; srspd[1] = 8'h11; settle();
      chk("fp_grant0", d_mreq_ready[1], 4'b0001);
    end
    step(1); mv[1] = 4'b0100; settle();
    chk("fp_grant2", d_mreq_ready[1], 4'b0100);
    step(1); mv[1] = 4'b0;
    step(1); srspv[1] = 1'b0;

    // Lock under back-pressure: master 1 held while master 0 appears.
    mv[1] = 4'b0010; sreqr[1] = 1'b0; settle();
    chk("lock_data0",   d_sreq_data[1],  16'h2222);
    chk("lock_noready", d_mreq_ready[1], 4'b0);
    step(1); mv[1] = 4'b0011; settle();
    chk("lock_data1", d_sreq_data[1],  16'h2222);
    chk("lock_held",  d_mreq_ready[1], 4'b0);
    step(1); settle();
    chk("lock_data2", d_sreq_data[1], 16'h2222);
    step(1); sreqr[1] = 1'b1; settle();
    chk("lock_fire_data", d_sreq_data[1],  16'h2222);
    chk("lock_fire",      d_mreq_ready[1], 4'b0010);
    step(1); mv[1] = 4'b0001; settle();
    chk("lock_next_grant", d_mreq_ready[1], 4'b0001);
    chk("lock_next_data",  d_sreq_data[1],  16'h1111);
    step(1); mv[1] = 4'b0; srspv[1] = 1'b1;
    step(2); srspv[1] = 1'b0;

    step(2);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
